// File: rtl/reflet_timer.sv
// reflet_timer: memory-mapped prescaled down-counter for the reflet_cpu bus.
// Four-register window (CTRL, PRESCALE, RELOAD, COUNT) with registered read
// data. An expiry flag drives a level interrupt when enabled.
module reflet_timer #(
  parameter int                  wordsize  = 8,
  parameter logic [wordsize-1:0] base_addr = 8'hF0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                irq
);

  localparam logic [wordsize-1:0] ONE = {{(wordsize-1){1'b0}}, 1'b1};

  logic                en_q, en_d;
  logic                auto_q, auto_d;
  logic                ie_q, ie_d;
  logic                flag_q, flag_d;
  logic [wordsize-1:0] psc_q, psc_d;
  logic [wordsize-1:0] prescale_q, prescale_d;
  logic [wordsize-1:0] reload_q, reload_d;
  logic [wordsize-1:0] count_q, count_d;
  logic [wordsize-1:0] rdata_q, rdata_d;

  logic                sel;
  logic                wr;
  logic                tick;
  logic                expire;
  logic [wordsize-1:0] ctrl_rd;

  assign sel    = (addr[wordsize-1:2] == base_addr[wordsize-1:2]);
  assign wr     = write_en & sel;
  assign tick   = en_q & (psc_q == prescale_q);
  assign expire = tick & (count_q == '0);

  // Next-state: prescaler and counter first, then bus writes override them
  // (write wins over tick, except FLAG where expiry wins over a clear).
  always_comb begin
    en_d       = en_q;
    auto_d     = auto_q;
    ie_d       = ie_q;
    flag_d     = flag_q;
    psc_d      = psc_q;
    prescale_d = prescale_q;
    reload_d   = reload_q;
    count_d    = count_q;

    if (tick) begin
      psc_d = '0;
    end else if (en_q) begin
      psc_d = psc_q + ONE;
    end

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - ONE;
      end else begin
        flag_d = 1'b1;
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    if (wr) begin
      case (addr[1:0])
        2'd0: begin
          en_d   = data_in[0];
          auto_d = data_in[1];
          ie_d   = data_in[2];
          if (data_in[7] && !expire) flag_d = 1'b0;
          // Enabling a stopped timer restarts the prescale phase.
          if (data_in[0] && !en_q) psc_d = '0;
        end
        2'd1:    prescale_d = data_in;
        2'd2:    reload_d   = data_in;
        default: count_d    = data_in;
      endcase
    end
  end

  // Read mux: CTRL image and window decode; outside the window reads 0.
  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd[0] = en_q;
    ctrl_rd[1] = auto_q;
    ctrl_rd[2] = ie_q;
    ctrl_rd[7] = flag_q;
    rdata_d    = '0;
    if (sel) begin
      case (addr[1:0])
        2'd0:    rdata_d = ctrl_rd;
        2'd1:    rdata_d = prescale_q;
        2'd2:    rdata_d = reload_q;
        default: rdata_d = count_q;
      endcase
    end
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      ie_q       <= 1'b0;
      flag_q     <= 1'b0;
      psc_q      <= '0;
      prescale_q <= '0;
      reload_q   <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
    end else begin
      en_q       <= en_d;
      auto_q     <= auto_d;
      ie_q       <= ie_d;
      flag_q     <= flag_d;
      psc_q      <= psc_d;
      prescale_q <= prescale_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
    end
  end

  assign data_out = rdata_q;
  assign irq      = flag_q & ie_q;

endmodule

// File: tb/tb_reflet_timer.sv
// tb_reflet_timer: directed tests for reflet_timer with hand-computed values.
module tb_reflet_timer;

  logic       clk;
  logic       reset;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       write_en;
  logic [7:0] data_out;
  logic       irq;

  int checks;
  int errors;

  reflet_timer #(.wordsize(8), .base_addr(8'hF0)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .data_out (data_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus write: one edge with write_en high; returns 1ns after that edge.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr     = a;
    data_in  = d;
    write_en = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  // Bus read: address presented for one edge, data sampled 1ns after it.
  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    addr     = a;
    write_en = 1'b0;
    @(posedge clk);
    #1;
    d = data_out;
  endtask

  task automatic idle(input int n);
    addr     = 8'h00;
    write_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs irq=%b data_out=%h expected 0/00", irq, data_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(8'hF0 + 8'(i), v);
      checks++;
      if (v !== 8'h00 || irq !== 1'b0) begin
        errors++;
        $display("FAIL reset_reg%0d got=%h irq=%b expected 00/0", i, v, irq);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] v;
    do_reset();
    bus_write(8'hF1, 8'h03);
    bus_write(8'hF2, 8'h04);
    bus_write(8'hF3, 8'h04);
    bus_write(8'hF0, 8'h07);           // enabling edge E0
    idle(19);                          // E0+19
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL auto_irq_early got=%b expected 0", irq);
    end
    idle(1);                           // E0+20
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL auto_irq_rise got=%b expected 1", irq);
    end
    bus_read(8'hF0, v);                // E0+21
    checks++;
    if (v !== 8'h87) begin
      errors++;
      $display("FAIL auto_ctrl got=%h expected 87", v);
    end
    bus_read(8'hF3, v);                // E0+22
    checks++;
    if (v !== 8'h04) begin
      errors++;
      $display("FAIL auto_count_reload got=%h expected 04", v);
    end
    bus_write(8'hF0, 8'h87);           // E0+23 clears FLAG
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL auto_irq_clear got=%b expected 0", irq);
    end
    idle(16);                          // E0+39
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL auto_irq_early2 got=%b expected 0", irq);
    end
    idle(1);                           // E0+40
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL auto_irq_rise2 got=%b expected 1", irq);
    end
    // Collision: FLAG clear on the expiry edge E0+60.
    idle(19);                          // E0+59
    bus_write(8'hF0, 8'h87);           // E0+60
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL collide_flag_irq got=%b expected 1", irq);
    end
    bus_read(8'hF0, v);                // E0+61
    checks++;
    if (v !== 8'h87) begin
      errors++;
      $display("FAIL collide_flag_ctrl got=%h expected 87", v);
    end
    // Collision: COUNT write on tick edge E0+64.
    idle(2);                           // E0+63
    bus_write(8'hF3, 8'h09);           // E0+64
    bus_read(8'hF3, v);                // E0+65
    checks++;
    if (v !== 8'h09) begin
      errors++;
      $display("FAIL collide_count got=%h expected 09", v);
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] v;
    do_reset();
    bus_write(8'hF1, 8'h00);
    bus_write(8'hF3, 8'h02);
    bus_write(8'hF0, 8'h05);           // E0
    idle(2);                           // E0+2
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_irq_early got=%b expected 0", irq);
    end
    idle(1);                           // E0+3
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_irq_rise got=%b expected 1", irq);
    end
    bus_read(8'hF0, v);
    checks++;
    if (v !== 8'h84) begin
      errors++;
      $display("FAIL oneshot_ctrl got=%h expected 84", v);
    end
    idle(10);
    bus_read(8'hF3, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL oneshot_count got=%h expected 00", v);
    end
    // Collision: EN=1 write on the one-shot expiry edge keeps EN set.
    do_reset();
    bus_write(8'hF0, 8'h05);           // E0, COUNT=0 PRESCALE=0
    bus_write(8'hF0, 8'h05);           // E0+1 expiry edge
    bus_read(8'hF0, v);
    checks++;
    if (v !== 8'h85) begin
      errors++;
      $display("FAIL oneshot_en_collide got=%h expected 85", v);
    end
  endtask

  task automatic test_decode();
    logic [7:0] v;
    logic [7:0] exp_v [4];
    exp_v = '{8'h00, 8'h00, 8'h33, 8'h00};
    do_reset();
    bus_write(8'hF2, 8'h33);
    bus_write(8'h10, 8'h55);
    bus_write(8'hEF, 8'h55);
    for (int i = 0; i < 4; i++) begin
      bus_read(8'hF0 + 8'(i), v);
      checks++;
      if (v !== exp_v[i]) begin
        errors++;
        $display("FAIL decode_reg%0d got=%h expected %h", i, v, exp_v[i]);
      end
    end
    bus_read(8'hF2, v);
    bus_read(8'h10, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL decode_outside got=%h expected 00", v);
    end
    bus_write(8'hF2, 8'h77);
    checks++;
    if (data_out !== 8'h33) begin
      errors++;
      $display("FAIL read_during_write got=%h expected 33", data_out);
    end
    bus_read(8'hF2, v);
    checks++;
    if (v !== 8'h77) begin
      errors++;
      $display("FAIL reload_after_write got=%h expected 77", v);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] v;
    do_reset();
    bus_write(8'hF1, 8'hFF);
    bus_write(8'hF2, 8'h03);
    bus_write(8'hF0, 8'h07);           // expiry 256 edges later, COUNT<=3
    idle(260);
    bus_read(8'hF3, v);
    checks++;
    if (v !== 8'h03) begin
      errors++;
      $display("FAIL midrst_count_pre got=%h expected 03", v);
    end
    bus_read(8'hF0, v);
    checks++;
    if (v !== 8'h87 || irq !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ctrl_pre got=%h irq=%b expected 87/1", v, irq);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async irq=%b data_out=%h expected 0/00", irq, data_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(8'hF0 + 8'(i), v);
      checks++;
      if (v !== 8'h00) begin
        errors++;
        $display("FAIL midrst_reg%0d got=%h expected 00", i, v);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    addr     = 8'h00;
    data_in  = 8'h00;
    write_en = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_auto_reload();
    test_one_shot();
    test_decode();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
